alu_serial_sequencer: RTL and testbench

//  Digit-serial ALU controller. Accepts one 32-bit operation through a valid/ready handshake.

---
 rtl/alu_serial_sequencer.sv | 174 +++++++++++++++++
 tb/tb_alu_serial_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_sequencer.sv
// Digit-serial ALU sequencer: accepts one operation, streams the operands
// LSB-first through DIGIT chained ALU cells per cycle, then presents the
// registered result, carry and zero flag until the consumer accepts it.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | ready for a new request (in_ready=1)
// RUN   | one digit per cycle through the cell chain; counter hits 0 on last
// DONE  | first cycle captures outputs; then out_valid=1 until out_ready
module alu_serial_sequencer #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_zero,
    output logic             busy
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : gBadDigit
        $error("alu_serial_sequencer: DIGIT must divide WIDTH");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

    stateT            state, nextState;
    logic             accept;
    logic             capture;
    logic [WIDTH-1:0] opA, opB, result;
    logic             carryReg;
    logic [CW-1:0]    digitCnt;
    logic             invA, invB, orSel, flood, arith;
    logic [DIGIT-1:0] cellOut;
    logic             cellCarry;
    logic             outValidReg;
    logic [WIDTH-1:0] outResultReg;
    logic             outCarryReg, outZeroReg;
    logic [4:0]       decoded;

    // Control word {!A, !B, Cin, Or, FloodCarry}; don't-care Cin is 0.
    function automatic logic [4:0] decodeOp(input logic [2:0] op);
        case (op)
            3'd0:    return 5'b00000;
            3'd1:    return 5'b01100;
            3'd2:    return 5'b11011;
            3'd3:    return 5'b11010;
            3'd4:    return 5'b00010;
            3'd5:    return 5'b00011;
            3'd6:    return 5'b01001;
            default: return 5'b00001;
        endcase
    endfunction

    assign decoded = decodeOp(in_op);

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= nextState;
    end

    // Next-state and handshake decode; flush overrides every transition.
    always_comb begin
        nextState = state;
        accept    = 1'b0;
        capture   = 1'b0;
        in_ready  = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid && !flush) begin
                    accept    = 1'b1;
                    nextState = RUN;
                end
            end
            RUN: begin
                if (digitCnt == '0) nextState = DONE;
            end
            DONE: begin
                if (!outValidReg) capture = !flush;
                else if (out_ready) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
        if (flush) nextState = IDLE;
    end

    // Chain of DIGIT cells fed from the carry register.
    always_comb begin
        logic c, aa, bb, ci;
        c       = carryReg;
        aa      = 1'b0;
        bb      = 1'b0;
        ci      = 1'b0;
        cellOut = '0;
        for (int i = 0; i < DIGIT; i++) begin
            aa         = opA[i] ^ invA;
            bb         = opB[i] ^ invB;
            ci         = flood | c;
            cellOut[i] = orSel ? ((aa | bb) ^ flood) : (aa ^ bb ^ ci);
            c          = (aa & bb) | (c & (aa ^ bb));
        end
        cellCarry = c;
    end

    // Operand/result shifters, carry register and down-counting digit timer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            opA      <= '0;
            opB      <= '0;
            result   <= '0;
            carryReg <= 1'b0;
            digitCnt <= '0;
            invA     <= 1'b0;
            invB     <= 1'b0;
            orSel    <= 1'b0;
            flood    <= 1'b0;
            arith    <= 1'b0;
        end else if (accept) begin
            opA      <= in_a;
            opB      <= in_b;
            invA     <= decoded[4];
            invB     <= decoded[3];
            carryReg <= decoded[2];
            orSel    <= decoded[1];
            flood    <= decoded[0];
            arith    <= (in_op <= 3'd1);
            digitCnt <= CW'(NDIG - 1);
        end else if (state == RUN) begin
            opA      <= opA >> DIGIT;
            opB      <= opB >> DIGIT;
            result   <= WIDTH'({cellOut, result} >> DIGIT);
            carryReg <= cellCarry;
            if (digitCnt != '0) digitCnt <= digitCnt - 1'b1;
        end
    end

    // Output holding registers; stable while out_valid waits for out_ready.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            outValidReg  <= 1'b0;
            outResultReg <= '0;
            outCarryReg  <= 1'b0;
            outZeroReg   <= 1'b0;
        end else if (flush || (state == DONE && outValidReg && out_ready)) begin
            outValidReg <= 1'b0;
        end else if (capture) begin
            outValidReg  <= 1'b1;
            outResultReg <= result;
            outCarryReg  <= carryReg & arith;
            outZeroReg   <= (result == '0);
        end
    end

    assign out_valid  = outValidReg;
    assign out_result = outResultReg;
    assign out_carry  = outCarryReg;
    assign out_zero   = outZeroReg;

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Directed + randomized bench for alu_serial_sequencer, checked against a
// plain-arithmetic reference model. A second DIGIT=4 instance covers latency.
module tb_alu_serial_sequencer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [2:0]  in_op;
    logic [31:0] in_a, in_b, out_result;
    logic        out_carry, out_zero, busy;

    logic        in_valid4, in_ready4, out_valid4, out_carry4, out_zero4, busy4;
    logic [31:0] out_result4;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_serial_sequencer #(.WIDTH(32), .DIGIT(1)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_carry(out_carry), .out_zero(out_zero), .busy(busy)
    );

    alu_serial_sequencer #(.WIDTH(32), .DIGIT(4)) dut4 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .flush(flush),
        .out_valid(out_valid4), .out_ready(out_ready), .out_result(out_result4),
        .out_carry(out_carry4), .out_zero(out_zero4), .busy(busy4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] r, output logic c);
        logic [32:0] s;
        c = 1'b0;
        case (op)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32]; end
            3'd1: begin r = a - b; c = (a >= b); end
            3'd2: r = a & b;
            3'd3: r = ~(a & b);
            3'd4: r = a | b;
            3'd5: r = ~(a | b);
            3'd6: r = a ^ b;
            default: r = ~(a ^ b);
        endcase
    endfunction

    // Issue one op, check latency and outputs, hold backpressure, then consume.
    task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input string tag);
        logic [31:0] er;
        logic        ec;
        int          lat;
        refModel(op, a, b, er, ec);
        check({tag, " in_ready"}, in_ready, 1);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        @(posedge clk); #1;
        in_valid = 1'b0; in_op = 3'($urandom); in_a = $urandom; in_b = $urandom;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, lat, 33);
        check({tag, " result"}, out_result, er);
        check({tag, " carry"}, out_carry, ec);
        check({tag, " zero"}, out_zero, (er == 32'd0));
        check({tag, " in_ready_done"}, in_ready, 0);
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            check({tag, " hold_valid"}, out_valid, 1);
            check({tag, " hold_result"}, out_result, er);
            check({tag, " hold_carry"}, out_carry, ec);
            check({tag, " hold_in_ready"}, in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " release_valid"}, out_valid, 0);
        check({tag, " release_busy"}, busy, 0);
    endtask

    initial begin
        logic [31:0] er, ra, rb;
        logic        ec, sawValid;
        int          lat;
        logic [2:0]  rop;

        rstn = 1'b0; in_valid = 1'b0; in_valid4 = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_op = 3'd0; in_a = '0; in_b = '0;
        #2;
        check("reset out_valid", out_valid, 0);
        check("reset in_ready", in_ready, 1);
        check("reset busy", busy, 0);
        check("reset result", out_result, 0);
        check("reset carry", out_carry, 0);
        check("reset zero", out_zero, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        runOp(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 0, "add_wrap");
        runOp(3'd1, 32'd5, 32'd7, 0, "sub_borrow");
        runOp(3'd1, 32'd7, 32'd7, 0, "sub_equal");
        for (int op = 2; op < 8; op++)
            runOp(3'(op), 32'hF0F0_1234, 32'h0FF0_FF00, 0, "logic_sweep");
        runOp(3'd0, 32'h1234_5678, 32'h8765_4321, 10, "backpressure");

        // flush during digit 17 of an ADD
        in_valid = 1'b1; in_op = 3'd0; in_a = $urandom; in_b = $urandom;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (17) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush busy", busy, 0);
        check("flush in_ready", in_ready, 1);
        sawValid = 1'b0;
        repeat (40) begin @(posedge clk); #1; sawValid |= out_valid; end
        check("flush no_valid", sawValid, 0);

        // request coincident with flush is dropped
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush_req busy", busy, 0);
        runOp(3'd0, 32'h0000_00FF, 32'h0000_0001, 0, "after_flush");

        // async reset pulse mid-RUN without a clock edge
        in_valid = 1'b1; in_op = 3'd6; in_a = $urandom; in_b = $urandom;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        #2 rstn = 1'b0;
        #1;
        check("rst_pulse busy", busy, 0);
        check("rst_pulse in_ready", in_ready, 1);
        check("rst_pulse out_valid", out_valid, 0);
        check("rst_pulse result", out_result, 0);
        check("rst_pulse carry", out_carry, 0);
        #2 rstn = 1'b1;
        @(posedge clk); #1;
        runOp(3'd1, 32'hDEAD_BEEF, 32'h1234_5678, 0, "after_reset");

        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(7));
            ra  = $urandom;
            rb  = (i % 6 == 0) ? ra : $urandom;
            runOp(rop, ra, rb, (i % 5 == 0) ? 2 : 0, "random");
        end

        // DIGIT=4 instance: same ADD, latency WIDTH/4+1
        for (int t = 0; t < 2; t++) begin
            ra = (t == 0) ? 32'hFFFF_FFFF : $urandom;
            rb = (t == 0) ? 32'h0000_0001 : $urandom;
            refModel(3'd0, ra, rb, er, ec);
            check("d4 in_ready", in_ready4, 1);
            in_valid4 = 1'b1; in_op = 3'd0; in_a = ra; in_b = rb;
            @(posedge clk); #1;
            in_valid4 = 1'b0;
            lat = 0;
            while (!out_valid4 && lat < 100) begin @(posedge clk); #1; lat++; end
            check("d4 latency", lat, 9);
            check("d4 result", out_result4, er);
            check("d4 carry", out_carry4, ec);
            check("d4 zero", out_zero4, (er == 32'd0));
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            check("d4 release busy", busy4, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
